// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core:
// control states, seven-segment codes and BCD digit limits.
package stopwatch_pkg;

   typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} sw_state_t;

   localparam int DP_BIT = 7;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS = 4'd5;

   // Active-low g..a patterns with the dp bit off
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic is_counting(sw_state_t s);
      return (s == RUN) || (s == LAP);
   endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Control pulses in, segment patterns and status out, between the
// stopwatch core (slave) and whatever drives it (master).
interface stopwatch_if;

   logic       start_stop;
   logic       clr;
   logic       lap;
   logic [7:0] in3;
   logic [7:0] in2;
   logic [7:0] in1;
   logic [7:0] in0;
   logic       running;
   logic       ovf;

   modport master (
      output start_stop, clr, lap,
      input  in3, in2, in1, in0, running, ovf
   );

   modport slave (
      input  start_stop, clr, lap,
      output in3, in2, in1, in0, running, ovf
   );

endinterface

// File: rtl/bcd_to_sseg.sv
// Combinational BCD digit to active-low seven-segment pattern with an
// optional decimal point; anything outside 0..9 blanks the digit.
module bcd_to_sseg
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dp_en,
   output logic [7:0] sseg
);

   always_comb begin
      case (bcd)
         4'd0:    sseg = SEG_0;
         4'd1:    sseg = SEG_1;
         4'd2:    sseg = SEG_2;
         4'd3:    sseg = SEG_3;
         4'd4:    sseg = SEG_4;
         4'd5:    sseg = SEG_5;
         4'd6:    sseg = SEG_6;
         4'd7:    sseg = SEG_7;
         4'd8:    sseg = SEG_8;
         4'd9:    sseg = SEG_9;
         default: sseg = SEG_BLANK;
      endcase
      if (dp_en && (bcd <= BCD_MAX)) sseg[DP_BIT] = 1'b0;
   end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: 0.1 s prescaler, cascaded BCD M.SS.T counter,
// run/stop/clear/lap control and registered seven-segment outputs.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 10
) (
   input  logic        clk,
   input  logic        reset,
   stopwatch_if.slave  sw
);

   localparam int             DIV     = CLK_HZ / TICK_HZ;
   localparam int             PW      = $clog2(DIV);
   localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);

   sw_state_t        state;
   sw_state_t        next_state;
   logic             running;
   logic [PW-1:0]    prescaler;
   logic [3:0][3:0]  live;
   logic [3:0][3:0]  lap_digits;
   logic [3:0][3:0]  disp;
   logic [3:0]       wrap;
   logic [3:0][7:0]  seg_next;
   logic [3:0][7:0]  seg_q;
   logic             ovf_pre;
   logic             ovf_q;
   logic             tick;
   logic             advance;
   logic             clear;

   // clr outranks start_stop, which outranks lap; illegal events fall through
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (sw.start_stop) next_state = RUN;
         RUN: begin
            if (sw.start_stop)  next_state = STOP;
            else if (sw.lap)    next_state = LAP;
         end
         LAP: begin
            if (sw.start_stop)  next_state = STOP;
            else if (sw.lap)    next_state = RUN;
         end
         STOP: begin
            if (sw.clr)             next_state = IDLE;
            else if (sw.start_stop) next_state = RUN;
         end
         default: next_state = IDLE;
      endcase
   end

   // A tick on the edge that leaves the counting states is dropped
   assign tick    = is_counting(state) && (prescaler == PRE_MAX);
   assign advance = tick && is_counting(next_state);
   assign clear   = (state == STOP) && (next_state == IDLE);

   assign wrap[0] = (live[0] == BCD_MAX);
   assign wrap[1] = wrap[0] && (live[1] == BCD_MAX);
   assign wrap[2] = wrap[1] && (live[2] == BCD_MAX_TENS);
   assign wrap[3] = wrap[2] && (live[3] == BCD_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         running    <= 1'b0;
         lap_digits <= '0;
      end else begin
         state   <= next_state;
         running <= is_counting(next_state);
         if ((state == RUN) && (next_state == LAP)) lap_digits <= live;
      end
   end

   // STOP holds the prescaler so a resumed run keeps the partial tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
      end else if ((state == IDLE) || clear) begin
         prescaler <= '0;
      end else if (is_counting(state)) begin
         prescaler <= tick ? '0 : prescaler + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live <= '0;
      end else if (clear) begin
         live <= '0;
      end else if (advance) begin
         live[0] <= wrap[0] ? 4'd0 : live[0] + 4'd1;
         if (wrap[0]) live[1] <= wrap[1] ? 4'd0 : live[1] + 4'd1;
         if (wrap[1]) live[2] <= wrap[2] ? 4'd0 : live[2] + 4'd1;
         if (wrap[2]) live[3] <= wrap[3] ? 4'd0 : live[3] + 4'd1;
      end
   end

   assign disp = (state == LAP) ? lap_digits : live;

   for (genvar i = 0; i < 4; i++) begin : g_dig
      bcd_to_sseg u_dig (
         .bcd   (disp[i]),
         .dp_en ((i == 1) || (i == 3)),
         .sseg  (seg_next[i])
      );
   end

   // ovf goes through two stages so it lines up with the 0.00.0 patterns
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q   <= {8'h40, 8'hC0, 8'h40, 8'hC0};
         ovf_pre <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         seg_q   <= seg_next;
         ovf_pre <= advance && wrap[3];
         ovf_q   <= ovf_pre;
      end
   end

   assign sw.in3     = seg_q[3];
   assign sw.in2     = seg_q[2];
   assign sw.in1     = seg_q[1];
   assign sw.in0     = seg_q[0];
   assign sw.running = running;
   assign sw.ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench: a DIV=10 and a DIV=2 core driven by the same pulses,
// each compared every cycle with an integer-time model plus directed checks.
module tb_stopwatch_core;

   localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;

   typedef struct {
      bit         ss;
      bit         cl;
      bit         lp;
      bit         exp_run;
      logic [7:0] exp_in0;
      logic [7:0] exp_in3;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ss = 1'b0, cl = 1'b0, lp = 1'b0;
   int   total = 0;
   int   bad = 0;

   int         m_div   [2];
   int         m_state [2];
   int         m_pre   [2];
   int         m_time  [2];
   int         m_lap   [2];
   bit         m_pend  [2];
   logic [7:0] e_seg   [2][4];
   logic       e_run   [2];
   logic       e_ovf   [2];
   logic [7:0] seg_tab [10];
   vec_t       vecs    [15];

   stopwatch_if sw_a ();
   stopwatch_if sw_b ();

   assign sw_a.start_stop = ss;
   assign sw_a.clr        = cl;
   assign sw_a.lap        = lp;
   assign sw_b.start_stop = ss;
   assign sw_b.clr        = cl;
   assign sw_b.lap        = lp;

   stopwatch_core #(.CLK_HZ(100), .TICK_HZ(10)) dut_a (.clk(clk), .reset(reset), .sw(sw_a));
   stopwatch_core #(.CLK_HZ(20),  .TICK_HZ(10)) dut_b (.clk(clk), .reset(reset), .sw(sw_b));

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int digit_of(int t, int pos);
      int secs;
      secs = (t / 10) % 60;
      case (pos)
         0:       return t % 10;
         1:       return secs % 10;
         2:       return secs / 10;
         default: return t / 600;
      endcase
   endfunction

   function automatic logic [7:0] seg_of(int d, bit dp);
      logic [7:0] c;
      c = seg_tab[d];
      if (dp) c[7] = 1'b0;
      return c;
   endfunction

   task automatic modelReset(input int k);
      m_state[k] = M_IDLE;
      m_pre[k]   = 0;
      m_time[k]  = 0;
      m_lap[k]   = 0;
      m_pend[k]  = 1'b0;
      e_run[k]   = 1'b0;
      e_ovf[k]   = 1'b0;
      for (int p = 0; p < 4; p++) e_seg[k][p] = seg_of(0, (p == 1) || (p == 3));
   endtask

   // One clock edge of the model, using the pulses currently applied
   task automatic modelEdge(input int k);
      int ns;
      int shown;
      bit cnt;
      bit tk;
      shown = (m_state[k] == M_LAP) ? m_lap[k] : m_time[k];
      for (int p = 0; p < 4; p++) e_seg[k][p] = seg_of(digit_of(shown, p), (p == 1) || (p == 3));
      e_ovf[k]  = m_pend[k];
      m_pend[k] = 1'b0;
      ns = m_state[k];
      case (m_state[k])
         M_IDLE:  if (ss) ns = M_RUN;
         M_RUN:   if (ss) ns = M_STOP; else if (lp) ns = M_LAP;
         M_LAP:   if (ss) ns = M_STOP; else if (lp) ns = M_RUN;
         default: if (cl) ns = M_IDLE; else if (ss) ns = M_RUN;
      endcase
      cnt = (m_state[k] == M_RUN) || (m_state[k] == M_LAP);
      tk  = cnt && (m_pre[k] == m_div[k] - 1);
      if ((m_state[k] == M_RUN) && (ns == M_LAP)) m_lap[k] = m_time[k];
      if ((m_state[k] == M_IDLE) || (ns == M_IDLE)) m_pre[k] = 0;
      else if (cnt) m_pre[k] = tk ? 0 : m_pre[k] + 1;
      if (ns == M_IDLE) begin
         m_time[k] = 0;
      end else if (tk && ((ns == M_RUN) || (ns == M_LAP))) begin
         if (m_time[k] == 5999) begin
            m_time[k] = 0;
            m_pend[k] = 1'b1;
         end else begin
            m_time[k] = m_time[k] + 1;
         end
      end
      e_run[k]   = (ns == M_RUN) || (ns == M_LAP);
      m_state[k] = ns;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input int k);
      logic [7:0] a3, a2, a1, a0;
      logic       ar, ao;
      if (k == 0) begin
         a3 = sw_a.in3; a2 = sw_a.in2; a1 = sw_a.in1; a0 = sw_a.in0; ar = sw_a.running; ao = sw_a.ovf;
      end else begin
         a3 = sw_b.in3; a2 = sw_b.in2; a1 = sw_b.in1; a0 = sw_b.in0; ar = sw_b.running; ao = sw_b.ovf;
      end
      total++;
      if ({a3, a2, a1, a0, ar, ao} !== {e_seg[k][3], e_seg[k][2], e_seg[k][1], e_seg[k][0], e_run[k], e_ovf[k]}) begin
         bad++;
         $display("[TB] FAIL model_div%0d t=%0t: got %h %h %h %h run=%b ovf=%b, expected %h %h %h %h run=%b ovf=%b",
                  m_div[k], $time, a3, a2, a1, a0, ar, ao,
                  e_seg[k][3], e_seg[k][2], e_seg[k][1], e_seg[k][0], e_run[k], e_ovf[k]);
      end
   endtask

   // Called at a falling edge: hold pulses over one rising edge, then compare
   task automatic applyStimulus(input bit s_i, input bit c_i, input bit l_i);
      ss = s_i; cl = c_i; lp = l_i;
      @(posedge clk);
      modelEdge(0);
      modelEdge(1);
      @(negedge clk);
      ss = 1'b0; cl = 1'b0; lp = 1'b0;
      checkOutput(0);
      checkOutput(1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bit found;
      seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      m_div   = '{10, 2};
      //           ss cl lp run in0    in3
      vecs[0]  = '{0, 1, 0, 0, 8'hC0, 8'h40};
      vecs[1]  = '{0, 0, 1, 0, 8'hC0, 8'h40};
      vecs[2]  = '{1, 0, 0, 1, 8'hC0, 8'h40};
      vecs[3]  = '{0, 1, 0, 1, 8'hC0, 8'h40};
      vecs[4]  = '{1, 1, 0, 0, 8'hC0, 8'h40};
      vecs[5]  = '{0, 0, 1, 0, 8'hC0, 8'h40};
      vecs[6]  = '{1, 1, 0, 0, 8'hC0, 8'h40};
      vecs[7]  = '{1, 0, 0, 1, 8'hC0, 8'h40};
      vecs[8]  = '{0, 0, 1, 1, 8'hC0, 8'h40};
      vecs[9]  = '{1, 0, 1, 0, 8'hC0, 8'h40};
      vecs[10] = '{1, 0, 0, 1, 8'hC0, 8'h40};
      vecs[11] = '{0, 1, 1, 1, 8'hC0, 8'h40};
      vecs[12] = '{0, 0, 1, 1, 8'hC0, 8'h40};
      vecs[13] = '{1, 0, 0, 0, 8'hC0, 8'h40};
      vecs[14] = '{0, 1, 0, 0, 8'hC0, 8'h40};

      modelReset(0);
      modelReset(1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkVal("reset_in3", sw_a.in3, 8'h40);
      checkVal("reset_in2", sw_a.in2, 8'hC0);
      checkVal("reset_in1", sw_a.in1, 8'h40);
      checkVal("reset_in0", sw_a.in0, 8'hC0);
      checkVal("reset_running", sw_a.running, 1'b0);
      checkVal("reset_ovf", sw_a.ovf, 1'b0);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].ss, vecs[i].cl, vecs[i].lp);
         checkVal($sformatf("vec%0d_running", i), sw_a.running, vecs[i].exp_run);
         checkVal($sformatf("vec%0d_in0", i), sw_a.in0, vecs[i].exp_in0);
         checkVal($sformatf("vec%0d_in3", i), sw_a.in3, vecs[i].exp_in3);
      end

      // First tick DIV cycles after start, then 600 ticks to 1.00.0
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(10);
      checkVal("first_tick_not_early", sw_a.in0, 8'hC0);
      idle(1);
      checkVal("first_tick_in0", sw_a.in0, 8'hF9);
      checkVal("first_tick_running", sw_a.running, 1'b1);
      idle(5990);
      checkVal("one_min_in3", sw_a.in3, 8'h79);
      checkVal("one_min_in2", sw_a.in2, 8'hC0);
      checkVal("one_min_in1", sw_a.in1, 8'h40);
      checkVal("one_min_in0", sw_a.in0, 8'hC0);

      // The DIV=2 core reaches 9.59.9 and wraps
      found = 1'b0;
      for (int i = 0; i < 8000 && !found; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (sw_b.ovf === 1'b1) found = 1'b1;
      end
      checkVal("ovf_seen", found, 1'b1);
      if (found) begin
         checkVal("wrap_in3", sw_b.in3, 8'h40);
         checkVal("wrap_in2", sw_b.in2, 8'hC0);
         checkVal("wrap_in1", sw_b.in1, 8'h40);
         checkVal("wrap_in0", sw_b.in0, 8'hC0);
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkVal("ovf_one_cycle", sw_b.ovf, 1'b0);
         checkVal("wrap_keeps_running", sw_b.running, 1'b1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);

      // Stop after 5 counts, resume: tick lands 5 cycles after the resume edge
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(4);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(20);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(5);
      checkVal("resume_not_early", sw_a.in0, 8'hC0);
      idle(1);
      checkVal("resume_tick", sw_a.in0, 8'hF9);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);

      // Lap hold at 0.03.4, release at 0.05.0
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(340);
      applyStimulus(1'b0, 1'b0, 1'b1);
      idle(109);
      checkVal("lap_frozen_in3", sw_a.in3, 8'h40);
      checkVal("lap_frozen_in2", sw_a.in2, 8'hC0);
      checkVal("lap_frozen_in1", sw_a.in1, 8'h30);
      checkVal("lap_frozen_in0", sw_a.in0, 8'h99);
      checkVal("lap_running", sw_a.running, 1'b1);
      idle(50);
      applyStimulus(1'b0, 1'b0, 1'b1);
      idle(1);
      checkVal("lap_release_in1", sw_a.in1, 8'h12);
      checkVal("lap_release_in0", sw_a.in0, 8'hC0);

      // Lap coinciding with a tick captures the pre-increment time
      idle(7);
      applyStimulus(1'b0, 1'b0, 1'b1);
      idle(1);
      checkVal("lap_on_tick_in1", sw_a.in1, 8'h12);
      checkVal("lap_on_tick_in0", sw_a.in0, 8'hC0);

      // Stop coinciding with a tick drops that tick
      idle(8);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(1);
      checkVal("stop_on_tick_in0", sw_a.in0, 8'hF9);
      checkVal("stop_on_tick_running", sw_a.running, 1'b0);

      // clr ignored while running; clr beats start_stop in STOP
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkVal("clr_in_run_running", sw_a.running, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkVal("clr_wins_running", sw_a.running, 1'b0);
      idle(1);
      checkVal("clr_in1", sw_a.in1, 8'h40);
      checkVal("clr_in0", sw_a.in0, 8'hC0);
      idle(15);
      checkVal("clr_stays_idle", sw_a.in0, 8'hC0);

      for (int i = 0; i < 3000; i++)
         applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);

      // Asynchronous reset in the middle of a cycle
      applyStimulus(1'b1, 1'b0, 1'b0);
      idle(37);
      #2;
      reset = 1'b1;
      #1;
      checkVal("async_reset_in3", sw_a.in3, 8'h40);
      checkVal("async_reset_in1", sw_a.in1, 8'h40);
      checkVal("async_reset_in0", sw_a.in0, 8'hC0);
      checkVal("async_reset_running", sw_a.running, 1'b0);
      modelReset(0);
      modelReset(1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(5);
      checkVal("after_reset_idle", sw_a.running, 1'b0);
      for (int i = 0; i < 1000; i++)
         applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
